// File: rtl/apb_regbank_pkg.sv
// ============================================================================
// Module      : apb_regbank_pkg
// Description : Shared types and constants for the APB register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_regbank_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/apb_regbank_storage.sv
// ============================================================================
// Module      : apb_regbank_storage
// Description : Word register array with byte-lane write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_regbank_storage #(
    parameter int               DATA_WIDTH = 32,
    parameter int               NBYTES     = DATA_WIDTH / 8,
    parameter int               NREGS      = 8,
    parameter logic [NREGS-1:0] RO_MASK    = 8'h80
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we_i,
    input  logic [$clog2(NREGS)-1:0]      idx_i,
    input  logic [NBYTES-1:0]             strb_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic [NREGS*DATA_WIDTH-1:0]   regs_o
);

    localparam int IW = $clog2(NREGS);

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            // Read-only slots have no storage; their value comes from hw_status.
            assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (we_i && (idx_i == IW'(i))) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (strb_i[b]) begin
                            data_q[b*8 +: 8] <= wdata_i[b*8 +: 8];
                        end
                    end
                end
            end

            assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_regbank.sv
// ============================================================================
// Module      : apb_regbank
// Description : APB slave register bank with wait states and RO status slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int               DATA_WIDTH  = 32,
    parameter int               ADDR_WIDTH  = 32,
    parameter int               NBYTES      = DATA_WIDTH / 8,
    parameter int               NREGS       = 8,
    parameter int               WAIT_STATES = 1,
    parameter logic [NREGS-1:0] RO_MASK     = 8'h80
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          PSEL,
    input  logic [ADDR_WIDTH-1:0]         PADDR,
    input  logic                          PWRITE,
    input  logic [NBYTES-1:0]             PSTRB,
    input  logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic                          PENABLE,
    output logic [DATA_WIDTH-1:0]         PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic [NREGS*DATA_WIDTH-1:0]   hw_status,
    output logic [NREGS*DATA_WIDTH-1:0]   reg_out
);

    localparam int                    IW         = $clog2(NREGS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NREGS * NBYTES);

    state_e                state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;

    logic [IW-1:0]         w_idx;
    logic                  w_ro;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdsel;

    assign w_idx = PADDR[IW+1:2];
    assign w_ro  = RO_MASK[w_idx];
    assign w_err = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT) || (PWRITE && w_ro);

    // Reset wins over completion so a transfer caught by reset never writes.
    assign w_ready = !PRESET && PSEL && PENABLE && (state_q == ST_ACCESS) && (cnt_q == '0);
    assign w_we    = w_ready && PWRITE && !w_err;

    assign w_rdsel = w_ro ? hw_status[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH]
                          : reg_out[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && w_err;
    assign PRDATA  = (w_ready && !PWRITE && !w_err) ? w_rdsel : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= WAIT_CNT_W'(WAIT_STATES);
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (PENABLE) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - WAIT_CNT_W'(1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    apb_regbank_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .NBYTES     (NBYTES),
        .NREGS      (NREGS),
        .RO_MASK    (RO_MASK)
    ) u_storage (
        .clk     (PCLK),
        .rst     (PRESET),
        .we_i    (w_we),
        .idx_i   (w_idx),
        .strb_i  (PSTRB),
        .wdata_i (PWDATA),
        .regs_o  (reg_out)
    );

endmodule

`default_nettype wire

// File: doc/apb_regbank.md
APB_REGBANK -- requirements
Module: apb_regbank

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, APB data width (multiple of 8).
- ADDR_WIDTH, 32, APB address width.
- NBYTES, DATA_WIDTH/8, strobe width.
- NREGS, 8, number of word registers (power of 2, >=2).
- WAIT_STATES, 1, access-phase cycles with PREADY=0 before completion (0..15).
- RO_MASK, 8'h80, bit i=1 makes register i read-only, sourced from hw_status.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK, in, 1, sole clock.
- PRESET, in, 1, synchronous active-high reset.
- PSEL, in, 1, slave select.
- PADDR, in, ADDR_WIDTH, byte address.
- PWRITE, in, 1, 1=write, 0=read.
- PSTRB, in, NBYTES, write byte lanes.
- PWDATA, in, DATA_WIDTH, write data.
- PENABLE, in, 1, access phase.
- PRDATA, out, DATA_WIDTH, read data.
- PREADY, out, 1, transfer completes this cycle.
- PSLVERR, out, 1, transfer error, valid only with PREADY=1.
- hw_status, in, NREGS*DATA_WIDTH, live values for read-only registers (slice i = register i).
- reg_out, out, NREGS*DATA_WIDTH, current contents of all RW registers (RO slices = 0).

Function
REQ-003 FSM SHALL have states IDLE, ACCESS; IDLE->ACCESS on PSEL=1 & PENABLE=0, loading wait counter with WAIT_STATES.
REQ-004 In ACCESS with PENABLE=1 and counter>0, counter SHALL decrement each cycle with PREADY=0.
REQ-005 PREADY SHALL be 1 combinationally in ACCESS when counter==0 and PENABLE=1; transfer = 2+WAIT_STATES cycles.
REQ-006 On the PREADY=1 cycle FSM SHALL return to IDLE; a setup phase in the next cycle SHALL be accepted (back-to-back).
REQ-007 PSEL deasserted while in ACCESS SHALL abort to IDLE, no write, no PREADY.
REQ-008 Register index SHALL be PADDR[log2(NREGS)+1:2]; error if PADDR[1:0]!=0 or PADDR >= NREGS*NBYTES.
REQ-009 Write to a RO register, or any decode error, SHALL assert PSLVERR with PREADY and leave all registers unchanged.
REQ-010 Valid write SHALL update only lanes with PSTRB[k]=1 at the PREADY edge; reg_out reflects it next cycle; PSTRB=0 is a legal no-op.
REQ-011 PRDATA SHALL equal the selected register (RW storage or hw_status slice sampled that cycle) when PREADY=1 & PWRITE=0 & no error, else all zeros.
REQ-012 PSTRB SHALL be ignored on reads; PSLVERR SHALL be 0 whenever PREADY=0.

Reset
REQ-013 PRESET=1 at a PCLK edge SHALL force IDLE, counter 0, all RW registers 0; PREADY, PSLVERR, PRDATA 0.
REQ-014 Reset during ACCESS SHALL discard the transfer without any register write.

Structure
REQ-015 Package apb_regbank_pkg SHALL hold the FSM state enum typedef and the WAIT_STATES counter-width constant.
REQ-016 Register storage with byte-strobe write SHALL be one sub-module, apb_regbank_storage; FSM and decode in apb_regbank.

Verification
REQ-017 Reset, then read addr 0x00 -> PREADY after 1 wait cycle, PRDATA=0, PSLVERR=0.
REQ-018 Write 0xDEADBEEF to 0x04 with PSTRB=4'b0101, prior value 0 -> reg_out slice 1 = 0x00AD00EF; read 0x04 returns same.
REQ-019 hw_status slice 7 = 0x12345678; write 0x1C -> PSLVERR=1, no change; read 0x1C -> 0x12345678, PSLVERR=0.
REQ-020 Read 0x20 (out of range) and 0x02 (misaligned) -> PSLVERR=1, PRDATA=0.
REQ-021 Back-to-back writes 0x00=0x1, 0x08=0x2 with no idle cycle -> both committed, each transfer 3 cycles.
REQ-022 PRESET=1 in ACCESS during write to 0x0C -> slice 3 stays 0; FSM IDLE next cycle.
